// File: rtl/mbt_pkg.sv
// Shared definitions for the Mandelbrot pixel dispatcher.
// Covers the Q4.11 coordinate format, the default view window, grid steps and the FSM encoding.
package mbt_pkg;

    localparam int FRAC_BITS = 11;
    localparam int WIDTH     = 16;

    localparam logic signed [WIDTH-1:0] X_MIN_DEF = 16'shF000;
    localparam logic signed [WIDTH-1:0] Y_MAX_DEF = 16'sh0960;

    localparam int         ITER_MAX     = 99;
    localparam logic [6:0] TIMEOUT_CODE = 7'h7F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARST,
        S_ASTART,
        S_WAIT,
        S_EMIT,
        S_NEXT
    } state_t;

    // Each zoom level halves the distance between neighbouring pixels.
    function automatic logic signed [WIDTH-1:0] grid_step(input logic [1:0] zoom);
        logic signed [WIDTH-1:0] step;
        case (zoom)
            2'd0:    step = 16'sh0008;
            2'd1:    step = 16'sh0004;
            2'd2:    step = 16'sh0002;
            default: step = 16'sh0001;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/mbt_coord_gen.sv
// Raster walker: pixel counters, incremental Q4.11 coordinates and the linear pixel address.
// Uses only adders. The coordinates wrap modulo 2^16.
module mbt_coord_gen
    import mbt_pkg::*;
#(
    parameter int               H_RES  = 800,
    parameter int               V_RES  = 600,
    parameter int               ADDR_W = 19,
    parameter logic [WIDTH-1:0] X_MIN  = X_MIN_DEF,
    parameter logic [WIDTH-1:0] Y_MAX  = Y_MAX_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    advance,
    input  logic [1:0]              zoom_level,
    output logic signed [WIDTH-1:0] c_real,
    output logic signed [WIDTH-1:0] c_img,
    output logic [ADDR_W-1:0]       addr,
    output logic                    last_col,
    output logic                    last_pix
);

    localparam int X_W = $clog2(H_RES + 1);
    localparam int Y_W = $clog2(V_RES + 1);

    logic [X_W-1:0]          x;
    logic [Y_W-1:0]          y;
    logic signed [WIDTH-1:0] step;

    assign last_col = (x == X_W'(H_RES - 1));
    assign last_pix = last_col && (y == Y_W'(V_RES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step   <= grid_step(2'd0);
            x      <= '0;
            y      <= '0;
            c_real <= X_MIN;
            c_img  <= Y_MAX;
            addr   <= '0;
        end else if (load) begin
            step   <= grid_step(zoom_level);
            x      <= '0;
            y      <= '0;
            c_real <= X_MIN;
            c_img  <= Y_MAX;
            addr   <= '0;
        end else if (advance) begin
            addr <= addr + ADDR_W'(1);
            // End of line: the imaginary axis points up, so moving down the screen subtracts.
            if (last_col) begin
                x      <= '0;
                c_real <= X_MIN;
                y      <= y + Y_W'(1);
                c_img  <= c_img - step;
            end else begin
                x      <= x + X_W'(1);
                c_real <= c_real + step;
            end
        end
    end

endmodule

// File: rtl/mbt_pixel_dispatcher.sv
// Frame dispatcher: runs one ALU job per pixel in raster order.
// Each pixel's iteration count (or the timeout code) goes to the frame-buffer writer.
module mbt_pixel_dispatcher
    import mbt_pkg::*;
#(
    parameter int               H_RES   = 800,
    parameter int               V_RES   = 600,
    parameter int               ADDR_W  = 19,
    parameter logic [WIDTH-1:0] X_MIN   = 16'hF000,
    parameter logic [WIDTH-1:0] Y_MAX   = 16'h0960,
    parameter int               TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic [1:0]              zoom_level,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    alu_rst,
    output logic                    alu_start,
    output logic signed [WIDTH-1:0] alu_c_real,
    output logic signed [WIDTH-1:0] alu_c_img,
    input  logic                    alu_valid,
    input  logic [6:0]              alu_iter,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [ADDR_W-1:0]       pix_addr,
    output logic [6:0]              pix_data,
    output logic                    timeout_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [ADDR_W-1:0] addr;
    logic              last_col;
    logic              last_pix;
    logic              load;
    logic              advance;

    assign load    = (state == S_IDLE) && frame_start;
    assign advance = (state == S_NEXT);

    mbt_coord_gen #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W),
        .X_MIN  (X_MIN),
        .Y_MAX  (Y_MAX)
    ) u_coord (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .advance    (advance),
        .zoom_level (zoom_level),
        .c_real     (alu_c_real),
        .c_img      (alu_c_img),
        .addr       (addr),
        .last_col   (last_col),
        .last_pix   (last_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            alu_rst     <= 1'b1;
            alu_start   <= 1'b0;
            pix_valid   <= 1'b0;
            pix_addr    <= '0;
            pix_data    <= '0;
            timeout_err <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_ARST;
                    end
                end
                S_ARST: begin
                    alu_rst   <= 1'b0;
                    alu_start <= 1'b1;
                    state     <= S_ASTART;
                end
                S_ASTART: begin
                    alu_start <= 1'b0;
                    tmo_cnt   <= '0;
                    state     <= S_WAIT;
                end
                // A result arriving on the final allowed cycle still wins over the timeout.
                S_WAIT: begin
                    if (alu_valid) begin
                        pix_data  <= alu_iter;
                        pix_addr  <= addr;
                        pix_valid <= 1'b1;
                        state     <= S_EMIT;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        pix_data    <= TIMEOUT_CODE;
                        pix_addr    <= addr;
                        pix_valid   <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= S_EMIT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_EMIT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        state     <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    alu_rst <= 1'b1;
                    if (last_col && last_pix) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        state <= S_ARST;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbt_pixel_dispatcher.sv
// Randomized scoreboard bench for mbt_pixel_dispatcher on a reduced 8x4 grid.
// It uses a behavioural ALU responder, random backpressure and a decoupled output monitor.
module tb_mbt_pixel_dispatcher;

    localparam int          H    = 8;
    localparam int          V    = 4;
    localparam int          AW   = 6;
    localparam int          NPIX = H * V;
    localparam logic [15:0] XMIN = 16'hF000;
    localparam logic [15:0] YMAX = 16'h0960;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          frame_start = 1'b0;
    logic [1:0]    zoom_level = 2'd0;
    logic          alu_valid = 1'b0;
    logic [6:0]    alu_iter = 7'd0;
    logic          pix_ready = 1'b0;
    logic          busy, frame_done, alu_rst, alu_start, pix_valid, timeout_err;
    logic [15:0]   alu_c_real, alu_c_img;
    logic [AW-1:0] pix_addr;
    logic [6:0]    pix_data;

    mbt_pixel_dispatcher #(
        .H_RES (H), .V_RES (V), .ADDR_W (AW),
        .X_MIN (XMIN), .Y_MAX (YMAX), .TIMEOUT (255)
    ) dut (
        .clk (clk), .rst_n (rst_n), .frame_start (frame_start), .zoom_level (zoom_level),
        .busy (busy), .frame_done (frame_done), .alu_rst (alu_rst), .alu_start (alu_start),
        .alu_c_real (alu_c_real), .alu_c_img (alu_c_img), .alu_valid (alu_valid),
        .alu_iter (alu_iter), .pix_valid (pix_valid), .pix_ready (pix_ready),
        .pix_addr (pix_addr), .pix_data (pix_data), .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [6:0]  data;
        bit          err;
        bit          tmo;
        longint      start;
        logic [15:0] exp_cr, exp_ci, obs_cr, obs_ci;
    } exp_t;

    exp_t   q[$];
    int     n_pass = 0, n_total = 0;
    longint cyc = 0;
    int     mode = 1;
    bit     hang = 1'b0;
    int     hs_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // ALU responder and reference model: derives each job's expected coordinates from its raster index.
    int          k = 0, lat_cnt = 0;
    bit          pend = 1'b0, ferr = 1'b0;
    logic [15:0] step = 16'h8;
    logic [6:0]  piter = 7'd0;

    always @(negedge clk) begin
        exp_t e;
        int   lat, r, x, y;
        alu_valid = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (frame_start && !busy) begin
                k    = 0;
                step = 16'h8 >> zoom_level;
                ferr = 1'b0;
            end
            if (alu_start) begin
                x = k % H;
                y = k / H;
                r = $urandom_range(0, 9);
                case (mode)
                    0: begin
                        if (r < 6)       lat = $urandom_range(1, 8);
                        else if (r == 6) lat = 255;
                        else if (r == 7) lat = 256;
                        else if (r == 8) lat = $urandom_range(100, 254);
                        else             lat = 0;
                    end
                    1:       lat = $urandom_range(1, 4);
                    default: lat = 0;
                endcase
                piter    = (mode == 1 && k == 0) ? 7'd5 : 7'($urandom_range(0, 99));
                e.tmo    = (lat == 0 || lat > 255);
                if (e.tmo) ferr = 1'b1;
                e.addr   = k;
                e.data   = e.tmo ? 7'h7F : piter;
                e.err    = ferr;
                e.start  = cyc;
                e.exp_cr = 16'(32'(XMIN) + x * 32'(step));
                e.exp_ci = 16'(32'(YMAX) - y * 32'(step));
                e.obs_cr = alu_c_real;
                e.obs_ci = alu_c_img;
                q.push_back(e);
                k++;
                pend    = (lat != 0);
                lat_cnt = lat;
            end else if (pend) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    alu_valid = 1'b1;
                    alu_iter  = piter;
                    pend      = 1'b0;
                end
            end else if (alu_rst && $urandom_range(0, 3) == 0) begin
                // A stale completion while the ALU is held in reset must be ignored.
                alu_valid = 1'b1;
                alu_iter  = 7'($urandom_range(0, 127));
            end
        end
    end

    // Monitor: owns pix_ready (so the handshake it predicts is the one the DUT sees) and all checks.
    int            burst = 0;
    bit            prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1, hang_rep = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [6:0]    prev_data = '0;

    always @(negedge clk) begin
        exp_t        e;
        logic [50:0] act_r, req_r;
        if (burst > 0) begin
            pix_ready = 1'b0;
            burst--;
        end else if ($urandom_range(0, 15) == 0) begin
            pix_ready = 1'b0;
            burst     = 9;
        end else begin
            pix_ready = ($urandom_range(0, 3) != 0);
        end

        if (!rst_n) begin
            q.delete();
            hs_cnt = 0;
            act_r  = {busy, frame_done, alu_rst, alu_start, pix_valid, timeout_err,
                      alu_c_real, alu_c_img, pix_addr, pix_data};
            req_r  = {6'b001000, XMIN, YMAX, {AW{1'b0}}, 7'd0};
            chk("reset_vals", act_r == req_r, longint'(act_r), longint'(req_r));
            prev_valid = 1'b0;
            prev_rst   = 1'b1;
        end else begin
            if (frame_start && !busy) hs_cnt = 0;
            if (alu_start)
                chk("start_seq", prev_rst && !alu_rst && !pix_valid,
                    longint'({prev_rst, alu_rst, pix_valid}), 64'h4);
            if (prev_valid && !prev_ready)
                chk("hold", pix_valid && pix_addr == prev_addr && pix_data == prev_data,
                    longint'({pix_valid, pix_addr, pix_data}), longint'({1'b1, prev_addr, prev_data}));
            if (pix_valid && !prev_valid && q.size() > 0 && q[0].tmo)
                chk("tmo_latency", (cyc - q[0].start) == 256, cyc - q[0].start, 256);
            if (pix_valid && pix_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_pix", 1'b0, longint'(pix_addr), -1);
                end else begin
                    e = q.pop_front();
                    chk("pix_addr", pix_addr == AW'(e.addr), longint'(pix_addr), longint'(e.addr));
                    chk("pix_data", pix_data == e.data, longint'(pix_data), longint'(e.data));
                    chk("timeout_err", timeout_err == e.err, longint'(timeout_err), longint'(e.err));
                    chk("c_real", e.obs_cr == e.exp_cr, longint'(e.obs_cr), longint'(e.exp_cr));
                    chk("c_img", e.obs_ci == e.exp_ci, longint'(e.obs_ci), longint'(e.exp_ci));
                    hs_cnt++;
                end
            end
            if (frame_done) begin
                chk("frame_done", hs_cnt == NPIX && !busy && q.size() == 0,
                    longint'(hs_cnt), longint'(NPIX));
                hs_cnt = 0;
            end
            prev_valid = pix_valid;
            prev_ready = pix_ready;
            prev_addr  = pix_addr;
            prev_data  = pix_data;
            prev_rst   = alu_rst;
        end
        if (hang && !hang_rep) begin
            chk("wait_bound", 1'b0, 0, 1);
            hang_rep = 1'b1;
        end
    end

    task automatic start_frame(input logic [1:0] z, input int m);
        @(posedge clk);
        #1 zoom_level = z;
        mode        = m;
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
    endtask

    task automatic wait_done(input int inject_at);
        bit seen = 1'b0, injected = 1'b0;
        logic [1:0] z;
        for (int i = 0; i < 30000 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
            if (inject_at >= 0 && !injected && hs_cnt >= inject_at && !seen) begin
                injected = 1'b1;
                z = zoom_level;
                #1 frame_start = 1'b1;
                zoom_level = ~z;
                @(posedge clk);
                #1 frame_start = 1'b0;
                zoom_level = z;
            end
        end
        if (!seen) hang = 1'b1;
    endtask

    task automatic abort_frame(input int at_pix);
        bit got = 1'b0;
        for (int i = 0; i < 30000 && hs_cnt < at_pix; i++) @(negedge clk);
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (alu_start) got = 1'b1;
        end
        if (!got) hang = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        start_frame(2'd0, 1); wait_done(-1);
        start_frame(2'd3, 0); wait_done(10);
        start_frame(2'($urandom_range(0, 3)), 2); wait_done(-1);
        start_frame(2'($urandom_range(0, 3)), 1); wait_done(-1);
        start_frame(2'($urandom_range(0, 3)), 0); abort_frame(20);
        start_frame(2'd1, 0); wait_done(-1);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
